// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receive path: frame FSM states, byte width, parity helper.
package ps2_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // PS/2 frames carry odd parity across the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [ByteW-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM and watchdog.
// Define PS2_GLITCH_FILTER_EN to qualify ps2_clk edges with a 4-high/4-low pattern.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SyncStages    = 3,
  parameter int unsigned TimeoutCycles = 5000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ps2_clk_i,
  input  logic             ps2_data_i,
  output logic             byte_valid_o,
  output logic [ByteW-1:0] byte_o,
  output logic             par_err_p_o,
  output logic             frm_err_p_o
);

  localparam int unsigned WdogW = $clog2(TimeoutCycles + 1);

  logic [SyncStages-1:0] clk_sync_q, data_sync_q;
  logic                  clk_s, data_s, fall;

  // Both lines idle high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SyncStages-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SyncStages-2:0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync_q[SyncStages-1];
  assign data_s = data_sync_q[SyncStages-1];

`ifdef PS2_GLITCH_FILTER_EN
  logic [6:0] hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= '1;
    else         hist_q <= {hist_q[5:0], clk_s};
  end

  assign fall = ({hist_q, clk_s} == 8'b1111_0000);
`else
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b1;
    else         prev_q <= clk_s;
  end

  assign fall = prev_q & ~clk_s;
`endif

  ps2_state_e       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [ByteW-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             valid, par_err, frm_err;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    valid   = 1'b0;
    par_err = 1'b0;
    frm_err = 1'b0;
    wdog_d  = (state_q == StIdle || fall) ? '0 : wdog_q + 1'b1;

    if (fall) begin
      case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            frm_err = 1'b1;
          end
        end
        StData: begin
          shift_d = {data_s, shift_q[ByteW-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data_s;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // A bad stop bit outranks a parity failure.
          if (!data_s)                             frm_err = 1'b1;
          else if (odd_parity_ok(shift_q, par_q)) valid   = 1'b1;
          else                                     par_err = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && wdog_q == WdogW'(TimeoutCycles - 1)) begin
      state_d = StIdle;
      frm_err = 1'b1;
      wdog_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      wdog_q  <= wdog_d;
    end
  end

  assign byte_valid_o = valid;
  assign byte_o       = shift_q;
  assign par_err_p_o  = par_err;
  assign frm_err_p_o  = frm_err;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with drop-on-full receive FIFO and sticky error flags.
// Optional build macro PS2_GLITCH_FILTER_EN enables ps2_clk edge glitch filtering.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  nextdata_n,
  input  logic                  clr_err,
  output logic [ByteW-1:0]      data,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic             byte_valid, par_err_p, frm_err_p;
  logic [ByteW-1:0] rx_byte;

  ps2_frame_rx #(
    .SyncStages   (SYNC_STAGES),
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk_i       (clk),
    .rst_ni      (clrn),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_valid_o(byte_valid),
    .byte_o      (rx_byte),
    .par_err_p_o (par_err_p),
    .frm_err_p_o (frm_err_p)
  );

  logic [ByteW-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, par_q, frm_q;
  logic                  full, pop, push, drop;

  assign full = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign pop  = ~nextdata_n & (count_q != '0);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push = byte_valid & (~full | pop);
  assign drop = byte_valid & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      par_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Set wins over a coincident clear.
      ovf_q   <= (ovf_q & ~clr_err) | drop;
      par_q   <= (par_q & ~clr_err) | par_err_p;
      frm_q   <= (frm_q & ~clr_err) | frm_err_p;
    end
  end

  assign data       = mem_q[rd_ptr_q];
  assign ready      = (count_q != '0);
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign parity_err = par_q;
  assign frame_err  = frm_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed vectors, corner sequences, random frames.
module tb_ps2_rx_fifo;

  localparam int TO    = 200;
  localparam int HALF  = 12;
  localparam int DEPTH = 8;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  logic       clk, clrn, ps2_clk, ps2_data, nextdata_n, clr_err;
  logic [7:0] data;
  logic       ready, overflow, parity_err, frame_err;
  logic [3:0] count;

  ps2_rx_fifo #(
    .DEPTH_LOG2    (3),
    .SYNC_STAGES   (3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .clr_err   (clr_err),
    .data      (data),
    .ready     (ready),
    .count     (count),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_par, m_frm;

  typedef struct {
    bit         clr_before;
    logic [7:0] d;
    bit         pflip;
    bit         stop;
    int         exp_cnt;
    bit         exp_par;
    bit         exp_frm;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit pflip, input bit stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = ~(^d) ^ pflip;
    f[10]  = stop;
    return f;
  endfunction

  // Reference behaviour for one complete frame arriving while no pop is in flight.
  task automatic model_frame(input logic [7:0] d, input bit pflip, input bit stop);
    if (!stop)                    m_frm = 1'b1;
    else if (pflip)               m_par = 1'b1;
    else if (mq.size() == DEPTH)  m_ovf = 1'b1;
    else                          mq.push_back(d);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop);
    logic [10:0] f;
    f = frame_bits(d, pflip, stop);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    cyc(2);
    model_frame(d, pflip, stop);
  endtask

  task automatic do_pop();
    nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    m_ovf = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk($sformatf("%s count", tag), int'(count), mq.size());
    chk($sformatf("%s ready", tag), int'(ready), int'(mq.size() > 0));
    if (mq.size() > 0) chk($sformatf("%s data", tag), int'(data), int'(mq[0]));
    chk($sformatf("%s overflow", tag), int'(overflow), int'(m_ovf));
    chk($sformatf("%s parity_err", tag), int'(parity_err), int'(m_par));
    chk($sformatf("%s frame_err", tag), int'(frame_err), int'(m_frm));
  endtask

  initial begin
    logic [10:0] f;
    int          kind, npop;
    logic [7:0]  rd;

    vecs[0] = '{0, 8'h1C, 0, 1, 1, 0, 0};
    vecs[1] = '{0, 8'h33, 0, 0, 1, 0, 1};
    vecs[2] = '{1, 8'h5A, 1, 1, 1, 1, 0};
    vecs[3] = '{1, 8'hC3, 1, 0, 1, 0, 1};
    vecs[4] = '{0, 8'hF0, 0, 1, 2, 0, 1};

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1; clr_err = 1'b0;
    cyc(3);
    check_state("reset");
    clrn = 1'b1;
    cyc(2);

    // Write latency: ready rises exactly LAT clk edges after the stop-bit pin edge.
    f = frame_bits(8'h1C, 0, 1);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      cyc(1);
      if (k == LAT - 1) chk("latency early ready", int'(ready), 0);
      if (k == LAT)     chk("latency ready", int'(ready), 1);
    end
    cyc(HALF - LAT);
    ps2_clk = 1'b1;
    mq.push_back(8'h1C);
    check_state("clean 1C");
    do_pop();
    check_state("pop 1C");

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].clr_before) do_clr();
      send_frame(vecs[v].d, vecs[v].pflip, vecs[v].stop);
      chk($sformatf("vec%0d count", v), int'(count), vecs[v].exp_cnt);
      chk($sformatf("vec%0d parity_err", v), int'(parity_err), int'(vecs[v].exp_par));
      chk($sformatf("vec%0d frame_err", v), int'(frame_err), int'(vecs[v].exp_frm));
      chk($sformatf("vec%0d overflow", v), int'(overflow), 0);
    end
    chk("vec head0", int'(data), 8'h1C);
    do_pop();
    chk("vec head1", int'(data), 8'hF0);
    do_pop();
    do_clr();
    check_state("vec drained");

    // Nine frames into an eight-deep FIFO: the ninth is dropped.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1);
    chk("full count", int'(count), 8);
    chk("full overflow", int'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("full pop%0d", i), int'(data), i);
      do_pop();
    end
    chk("full drained ready", int'(ready), 0);
    do_pop();
    chk("pop on empty count", int'(count), 0);
    do_clr();

    // Watchdog: five bits then silence.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    cyc(TO - 50);
    chk("wdog early", int'(frame_err), 0);
    cyc(80);
    chk("wdog fired", int'(frame_err), 1);
    m_frm = 1'b1;
    do_clr();
    send_frame(8'hF0, 0, 1);
    check_state("after timeout F0");
    do_pop();

    // Start bit of 1 in idle is a framing error.
    ps2_bit(1'b1);
    cyc(2);
    m_frm = 1'b1;
    check_state("bad start");
    do_clr();

    // clr_err held across a new framing error: the set wins that cycle.
    clr_err = 1'b1;
    f = frame_bits(8'h33, 0, 0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(LAT);
    chk("set beats clr", int'(frame_err), 1);
    cyc(1);
    chk("clr after set", int'(frame_err), 0);
    clr_err = 1'b0;
    cyc(HALF - LAT - 1);
    ps2_clk = 1'b1;
    cyc(2);
    check_state("set-wins end");

    // Full FIFO with a pop landing on the same cycle as the 0xAA write.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 1);
    f = frame_bits(8'hAA, 0, 1);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(LAT - 1);
    nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    void'(mq.pop_front());
    mq.push_back(8'hAA);
    chk("pushpop count", int'(count), 8);
    chk("pushpop overflow", int'(overflow), 0);
    cyc(HALF - LAT);
    ps2_clk = 1'b1;
    cyc(2);
    for (int i = 0; i < 8; i++) begin
      rd = mq[0];
      chk($sformatf("pushpop drain%0d", i), int'(data), int'(rd));
      do_pop();
    end
    chk("pushpop last was AA", int'(rd), 8'hAA);
    check_state("pushpop drained");

    // Reset mid-frame clears everything immediately.
    send_frame(8'h42, 0, 1);
    ps2_bit(1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    clrn = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
    check_state("async reset");
    cyc(2);
    clrn = 1'b1;
    cyc(2);
    send_frame(8'h6B, 0, 1);
    check_state("post-reset 6B");
    do_pop();

    // Random frames and pops against the queue model.
    for (int it = 0; it < 40; it++) begin
      npop = (it % 10 < 5) ? 0 : $urandom_range(0, 3);
      for (int p = 0; p < npop; p++) do_pop();
      if ($urandom_range(0, 7) == 0) do_clr();
      kind = $urandom_range(0, 9);
      send_frame(8'($urandom), kind == 7, kind != 8);
      check_state($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with a configurable-depth receive FIFO. It replaces the fixed 8-entry keyboard receiver.
- Adds a frame-timeout watchdog.
- Adds explicit per-cause error flags.
- Adds a drop-on-full policy, so the FIFO is never silently overwritten.
- Exposes an occupancy count.

It sits between the PS/2 pins and the game/scan-code decoding logic, which drains bytes via the `nextdata_n` handshake.

Parameters:
- `DEPTH_LOG2`, 3: FIFO depth = 2**`DEPTH_LOG2` entries (legal 1..6).
- `SYNC_STAGES`, 3: synchroniser flops on `ps2_clk` and `ps2_data` (legal 2..4).
- `TIMEOUT_CYCLES`, 5000: `clk` cycles without a `ps2_clk` falling edge, mid-frame, before the frame is aborted (≥16).

Ports:
- `clk`  in  1  system clock
- `clrn`  in  1  asynchronous active-low reset
- `ps2_clk`  in  1  raw PS/2 clock pin
- `ps2_data`  in  1  raw PS/2 data pin
- `nextdata_n`  in  1  active-low pop strobe, one entry per cycle held low
- `clr_err`  in  1  synchronous clear of all sticky error flags
- `data`  out  8  FIFO head byte; valid while `ready`=1
- `ready`  out  1  FIFO non-empty
- `count`  out  `DEPTH_LOG2`+1  current occupancy, 0..2**`DEPTH_LOG2`
- `overflow`  out  1  sticky: a good frame was dropped because the FIFO was full
- `parity_err`  out  1  sticky: frame discarded, even parity over data+parity bits
- `frame_err`  out  1  sticky: bad start bit, bad stop bit, or timeout

Behaviour:
- Reset: async on `clrn`=0.
  - Outputs `ready`, `count`, `overflow`, `parity_err`, `frame_err` = 0.
  - Pointers = 0, FSM = IDLE, watchdog = 0; `data` is don't-care.
  - Synchroniser flops reset to 1 (bus idle-high).
  - Reset mid-frame discards the partial frame.
- Edge detect: `fall` = previous synced `ps2_clk` & ~current synced `ps2_clk`, one `clk` wide. `ps2_data` is sampled from its synchronised copy on `fall`.
- Frame FSM, advancing only on `fall`:
  - IDLE: sample start bit. If 0, go to DATA with bit index 0. If 1, set `frame_err` and stay in IDLE.
  - DATA: shift in the LSB first. After bit 7, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: evaluate the frame, then go to IDLE.
    - Stop bit = 1 and odd parity holds: the byte is good.
    - Stop bit = 0: set `frame_err`; this takes precedence over parity.
    - Parity even: set `parity_err`.
    - Bad frames are never written to the FIFO.
- Watchdog:
  - Cleared on every `fall` and whenever the FSM is in IDLE.
  - Otherwise increments each cycle.
  - On reaching `TIMEOUT_CYCLES`: FSM goes to IDLE, `frame_err` sets, the partial byte is discarded.
- FIFO write:
  - A good byte is written in the same cycle as the STOP `fall`. `ready`/`count` reflect it on the next cycle (latency 1 `clk` after the detected edge).
  - If `count` = depth when the byte arrives, the byte is dropped, `overflow` sets, and the existing contents are unchanged.
- FIFO read:
  - `data` is combinational from `mem[rd_ptr]`.
  - `nextdata_n`=0 with `ready`=1 pops one entry per `clk`.
  - `nextdata_n`=0 with `ready`=0 is ignored; no pointer movement.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - When full, a simultaneous pop frees the slot, so the push succeeds with no overflow.
- Pointers: `DEPTH_LOG2` bits, natural wrap-around. `count` is tracked separately, so full and empty are unambiguous.
- Sticky errors:
  - Hold until `clr_err`=1.
  - If `clr_err` and a new error event fall in the same cycle, the flag stays/sets to 1 (the set wins).

Optional Feature:
`PS2_GLITCH_FILTER_EN`
- Defined: `fall` requires synced `ps2_clk` to read 1 for 4 consecutive `clk` cycles followed by 0 for 4 consecutive cycles. This rejects sub-4-cycle glitches and adds 3 cycles of edge latency.
- Undefined: plain two-flop edge detect as specified above.

Decomposition:
- Package `ps2_pkg`: FSM state enum (IDLE, DATA, PARITY, STOP) and the data byte width constant 8.
- One sub-module, `ps2_frame_rx`: synchroniser, optional filter, FSM, and watchdog. It emits `byte_valid` (1-cycle), `byte`, `par_err_p`, and `frm_err_p` pulses.
- The top level holds the FIFO, count, and sticky flags.

Test Plan:
- Clean frame `0x1C` (start 0, bits, parity 0, stop 1) → 1 cycle after the STOP edge: `ready`=1, `data`=`0x1C`, `count`=1, no errors. One `nextdata_n` pulse → `ready`=0, `count`=0.
- 9 good frames `0x01`..`0x09` with no reads (default depth 8) → `count`=8, `overflow`=1. Pops return `0x01`..`0x08`; `0x09` is absent.
- Frame `0x5A` with the parity bit flipped → no write, `parity_err`=1, `count` unchanged. `clr_err` pulse → `parity_err`=0.
- Frame `0x33` with stop bit 0 → no write, `frame_err`=1, `parity_err` stays 0.
- 5 bits then `ps2_clk` held high for `TIMEOUT_CYCLES` → `frame_err`=1, FSM returns to IDLE. Next clean frame `0xF0` is received correctly.
- FIFO full while a pop and the write of frame `0xAA` hit the same cycle → `count` stays 8, `overflow`=0, `0xAA` is read out last. Separately, assert `clrn` mid-frame → all outputs 0 immediately; the following frame is received cleanly.
